// File: rtl/branch_compare_unit.sv
// ---------------------------------------------------------------------------
// branch_compare_unit
//
// Pipelined branch-condition evaluator for the ID/EX branch path. The branch
// condition is evaluated combinationally on the incoming operands. The result
// and its tag are then carried through DEPTH register stages. The last stage
// drives the out_* ports. Saturating counters track handed-off results and
// the taken outcomes among them.
//
// Handshake (both sides): a beat moves when valid && ready are high at a
// rising clk edge. valid must not depend on ready. On the output side,
// out_taken and out_tag stay stable while out_valid is high and out_ready is
// low.
//
// Parameters
//   WIDTH  operand width in bits (>= 2)
//   DEPTH  pipeline register stages, input to output (1..4)
//   TAG_W  width of the pass-through tag
//   CNT_W  width of the statistics counters
//
// Ports
//   clk        rising-edge clock
//   clrn       asynchronous active-low reset
//   in_valid   operands/op valid this cycle
//   in_ready   unit can accept a beat this cycle
//   op         condition select:
//                000 EQ, 001 NE, 010 LEZ, 011 GTZ,
//                100 LTZ, 101 GEZ, 110 LT, 111 LTU
//   qa         operand rs
//   qb         operand rt (ignored by the single-operand ops)
//   tag        carried alongside the result
//   flush      kill every in-flight result at the next edge
//   cnt_clr    synchronous clear of both counters (wins over a handoff)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_taken  branch condition true
//   out_tag    tag of the current result
//   cmp_cnt    handed-off results, saturating
//   taken_cnt  handed-off results with out_taken = 1, saturating
// ---------------------------------------------------------------------------
module branch_compare_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] qa,
    input  logic [WIDTH-1:0] qb,
    input  logic [TAG_W-1:0] tag,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] cmp_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LEZ = 3'b010;
    localparam logic [2:0] OP_GTZ = 3'b011;
    localparam logic [2:0] OP_LTZ = 3'b100;
    localparam logic [2:0] OP_GEZ = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_LTU = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Condition evaluation
    // ------------------------------------------------------------------
    logic sign_a;
    logic a_zero;
    logic a_eq_b;
    logic lt_signed;
    logic lt_unsigned;
    logic cond;

    assign sign_a      = qa[WIDTH-1];
    assign a_zero      = (qa == '0);
    assign a_eq_b      = (qa == qb);
    assign lt_signed   = ($signed(qa) < $signed(qb));
    assign lt_unsigned = (qa < qb);

    // The single-operand tests against zero need only the sign bit and a
    // zero detect, so no subtractor is spent on them.
    always_comb begin
        cond = 1'b0;
        case (op)
            OP_EQ:   cond = a_eq_b;
            OP_NE:   cond = !a_eq_b;
            OP_LEZ:  cond = sign_a || a_zero;
            OP_GTZ:  cond = !sign_a && !a_zero;
            OP_LTZ:  cond = sign_a;
            OP_GEZ:  cond = !sign_a;
            OP_LT:   cond = lt_signed;
            OP_LTU:  cond = lt_unsigned;
            default: cond = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic             advance;
    logic             transfer;
    logic             handoff;

    logic [DEPTH-1:0] stg_valid;
    logic [DEPTH-1:0] stg_taken;
    logic [TAG_W-1:0] stg_tag [DEPTH];

    // One global stall: the whole pipe moves only when the last stage is
    // empty or being drained. Bubbles are carried along and not collapsed.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign transfer  = in_valid && in_ready;
    assign handoff   = out_valid && out_ready;

    assign out_valid = stg_valid[DEPTH-1];
    assign out_taken = stg_taken[DEPTH-1];
    assign out_tag   = stg_tag[DEPTH-1];

    // Valid bits: flush overrides everything, including a beat accepted in
    // the same cycle, which is therefore discarded.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stg_valid <= '0;
        end else if (flush) begin
            stg_valid <= '0;
        end else if (advance) begin
            stg_valid[0] <= transfer;
            for (int i = 1; i < DEPTH; i++) begin
                stg_valid[i] <= stg_valid[i-1];
            end
        end
    end

    // Payload: reset so the out_* ports read zero until the first result.
    // Stage 0 loads only on an accepted beat, so nothing but real results
    // (or the reset zeros) ever reaches the output registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stg_taken <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stg_tag[i] <= '0;
            end
        end else if (advance) begin
            if (transfer) begin
                stg_taken[0] <= cond;
                stg_tag[0]   <= tag;
            end
            for (int i = 1; i < DEPTH; i++) begin
                stg_taken[i] <= stg_taken[i-1];
                stg_tag[i]   <= stg_tag[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outcome statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cmp_cnt   <= '0;
            taken_cnt <= '0;
        end else if (cnt_clr) begin
            cmp_cnt   <= '0;
            taken_cnt <= '0;
        end else if (handoff) begin
            if (cmp_cnt != CNT_MAX) begin
                cmp_cnt <= cmp_cnt + CNT_ONE;
            end
            if (out_taken && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_compare_unit.sv
`timescale 1ns/1ps
module tb_branch_compare_unit;

  localparam int W  = 32;
  localparam int TW = 5;

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LEZ = 3'b010;
  localparam logic [2:0] OP_GTZ = 3'b011;
  localparam logic [2:0] OP_LTZ = 3'b100;
  localparam logic [2:0] OP_GEZ = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_LTU = 3'b111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic          in_valid, flush, cnt_clr, out_ready;
  logic [2:0]    op;
  logic [W-1:0]  qa, qb;
  logic [TW-1:0] tag;
  logic          drv_exp;

  // DEPTH=1, CNT_W=4 instance
  logic          in_ready1, out_valid1, out_taken1;
  logic [TW-1:0] out_tag1;
  logic [3:0]    cmp_cnt1, taken_cnt1;
  // DEPTH=3, CNT_W=16 instance
  logic          in_ready3, out_valid3, out_taken3;
  logic [TW-1:0] out_tag3;
  logic [15:0]   cmp_cnt3, taken_cnt3;

  branch_compare_unit #(.WIDTH(W), .DEPTH(1), .TAG_W(TW), .CNT_W(4)) u1 (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready1),
    .op(op), .qa(qa), .qb(qb), .tag(tag), .flush(flush), .cnt_clr(cnt_clr),
    .out_valid(out_valid1), .out_ready(out_ready), .out_taken(out_taken1),
    .out_tag(out_tag1), .cmp_cnt(cmp_cnt1), .taken_cnt(taken_cnt1)
  );

  branch_compare_unit #(.WIDTH(W), .DEPTH(3), .TAG_W(TW), .CNT_W(16)) u3 (
    .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready3),
    .op(op), .qa(qa), .qb(qb), .tag(tag), .flush(flush), .cnt_clr(cnt_clr),
    .out_valid(out_valid3), .out_ready(out_ready), .out_taken(out_taken3),
    .out_tag(out_tag3), .cmp_cnt(cmp_cnt3), .taken_cnt(taken_cnt3)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference branch condition, written from the instruction semantics.
  function automatic logic ref_taken(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (o)
      OP_EQ:   return a == b;
      OP_NE:   return a != b;
      OP_LEZ:  return sa <= 0;
      OP_GTZ:  return sa > 0;
      OP_LTZ:  return sa < 0;
      OP_GEZ:  return sa >= 0;
      OP_LT:   return sa < sb;
      default: return a < b;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_raw(input logic v, input logic [2:0] o, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [TW-1:0] t, input logic e);
    in_valid = v;
    op       = o;
    qa       = a;
    qb       = b;
    tag      = t;
    drv_exp  = e;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] t);
    drive_raw(v, o, a, b, t, ref_taken(o, a, b));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      drive(1'b0, OP_EQ, '0, '0, '0);
      flush   = 1'b0;
      cnt_clr = 1'b0;
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [TW:0] exp_q1[$];
  logic [TW:0] exp_q3[$];
  int          m_cmp1, m_tkn1, m_cmp3, m_tkn3;
  logic        p_stall1 = 1'b0, p_stall3 = 1'b0;
  logic [TW:0] p_out1, p_out3;

  always @(negedge clk) begin
    logic [TW:0] e;
    if (!clrn) begin
      exp_q1.delete();
      m_cmp1   = 0;
      m_tkn1   = 0;
      p_stall1 = 1'b0;
    end else begin
      check("u1_cmp_cnt", 32'(cmp_cnt1), m_cmp1);
      check("u1_taken_cnt", 32'(taken_cnt1), m_tkn1);
      check("u1_in_ready", 32'(in_ready1), 32'(!out_valid1 || out_ready));
      if (p_stall1) begin
        check("u1_hold_valid", 32'(out_valid1), 1);
        check("u1_hold_data", 32'({out_taken1, out_tag1}), 32'(p_out1));
      end
      e = '0;
      if (out_valid1 && out_ready) begin
        if (exp_q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u1_unexpected_out: got tag %0d, expected no output at %0t", out_tag1, $time);
        end else begin
          e = exp_q1.pop_front();
          check("u1_result", 32'({out_taken1, out_tag1}), 32'(e));
        end
      end
      if (cnt_clr) begin
        m_cmp1 = 0;
        m_tkn1 = 0;
      end else if (out_valid1 && out_ready) begin
        if (m_cmp1 < 15) m_cmp1++;
        if (e[TW] && m_tkn1 < 15) m_tkn1++;
      end
      if (flush) exp_q1.delete();
      else if (in_valid && (!out_valid1 || out_ready)) exp_q1.push_back({drv_exp, tag});
      p_stall1 = out_valid1 && !out_ready && !flush;
      p_out1   = {out_taken1, out_tag1};
    end
  end

  always @(negedge clk) begin
    logic [TW:0] e;
    if (!clrn) begin
      exp_q3.delete();
      m_cmp3   = 0;
      m_tkn3   = 0;
      p_stall3 = 1'b0;
    end else begin
      check("u3_cmp_cnt", 32'(cmp_cnt3), m_cmp3);
      check("u3_taken_cnt", 32'(taken_cnt3), m_tkn3);
      check("u3_in_ready", 32'(in_ready3), 32'(!out_valid3 || out_ready));
      if (p_stall3) begin
        check("u3_hold_valid", 32'(out_valid3), 1);
        check("u3_hold_data", 32'({out_taken3, out_tag3}), 32'(p_out3));
      end
      e = '0;
      if (out_valid3 && out_ready) begin
        if (exp_q3.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u3_unexpected_out: got tag %0d, expected no output at %0t", out_tag3, $time);
        end else begin
          e = exp_q3.pop_front();
          check("u3_result", 32'({out_taken3, out_tag3}), 32'(e));
        end
      end
      if (cnt_clr) begin
        m_cmp3 = 0;
        m_tkn3 = 0;
      end else if (out_valid3 && out_ready) begin
        if (m_cmp3 < 65535) m_cmp3++;
        if (e[TW] && m_tkn3 < 65535) m_tkn3++;
      end
      if (flush) exp_q3.delete();
      else if (in_valid && (!out_valid3 || out_ready)) exp_q3.push_back({drv_exp, tag});
      p_stall3 = out_valid3 && !out_ready && !flush;
      p_out3   = {out_taken3, out_tag3};
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] qa;
    logic [W-1:0] qb;
    logic         exp;
  } vec_t;

  vec_t vecs[19];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- main test ----------------
  initial begin
    int next_tag;
    int lat1;
    int lat3;

    vecs[0]  = '{OP_EQ,  32'h0000_1234, 32'h0000_1234, 1'b1};
    vecs[1]  = '{OP_NE,  32'h0000_1234, 32'h0000_1234, 1'b0};
    vecs[2]  = '{OP_LT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
    vecs[3]  = '{OP_LTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[4]  = '{OP_LEZ, 32'h0000_0000, 32'h0000_0005, 1'b1};
    vecs[5]  = '{OP_GTZ, 32'h0000_0000, 32'h0000_0005, 1'b0};
    vecs[6]  = '{OP_GEZ, 32'h0000_0000, 32'h0000_0005, 1'b1};
    vecs[7]  = '{OP_LTZ, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[8]  = '{OP_LTZ, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[9]  = '{OP_GTZ, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[10] = '{OP_LEZ, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{OP_GEZ, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[12] = '{OP_LT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[13] = '{OP_LTU, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0};
    vecs[14] = '{OP_EQ,  32'h0000_0005, 32'h0000_0006, 1'b0};
    vecs[15] = '{OP_NE,  32'h0000_0005, 32'h0000_0006, 1'b1};
    vecs[16] = '{OP_LT,  32'h0000_0005, 32'h0000_0005, 1'b0};
    vecs[17] = '{OP_LTU, 32'h0000_0000, 32'h0000_0001, 1'b1};
    vecs[18] = '{OP_LEZ, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};

    // Reset state
    clrn      = 1'b0;
    flush     = 1'b0;
    cnt_clr   = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, OP_EQ, '0, '0, '0);
    #1;
    check("rst_out_valid1", 32'(out_valid1), 0);
    check("rst_out_valid3", 32'(out_valid3), 0);
    check("rst_out_data1", 32'({out_taken1, out_tag1}), 0);
    check("rst_out_data3", 32'({out_taken3, out_tag3}), 0);
    check("rst_cnt1", 32'({cmp_cnt1, taken_cnt1}), 0);
    check("rst_cnt3", 32'({cmp_cnt3, taken_cnt3}), 0);
    check("rst_in_ready1", 32'(in_ready1), 1);
    check("rst_in_ready3", 32'(in_ready3), 1);
    repeat (2) @(posedge clk);
    #3 clrn = 1'b1;

    // Table: one vector per cycle; DEPTH=1 result must appear one cycle later.
    for (int i = 0; i < 19; i++) begin
      cyc();
      if (i > 0) begin
        check("vec_valid_d1", 32'(out_valid1), 1);
        check("vec_taken_d1", 32'(out_taken1), 32'(vecs[i-1].exp));
        check("vec_tag_d1", 32'(out_tag1), 32'(i - 1));
      end
      drive_raw(1'b1, vecs[i].op, vecs[i].qa, vecs[i].qb, TW'(i), vecs[i].exp);
    end
    cyc();
    check("vec_taken_last", 32'(out_taken1), 32'(vecs[18].exp));
    drive(1'b0, OP_EQ, '0, '0, '0);
    idle(5);
    check("vec_drain1", exp_q1.size(), 0);
    check("vec_drain3", exp_q3.size(), 0);

    // Backpressure on DEPTH=3: tags 1..6, out_ready low in cycles 4-6.
    next_tag = 1;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      out_ready = !(c >= 4 && c <= 6);
      if (next_tag <= 6) drive(1'b1, OP_GEZ, W'(c), '0, TW'(next_tag));
      else drive(1'b0, OP_EQ, '0, '0, '0);
      #1;
      if (c >= 4 && c <= 6) begin
        check("bp_in_ready", 32'(in_ready3), 0);
        check("bp_out_valid", 32'(out_valid3), 1);
        check("bp_out_tag", 32'(out_tag3), 1);
      end
      if (in_valid && in_ready3) next_tag++;
    end
    check("bp_all_sent", next_tag, 7);
    check("bp_drained", exp_q3.size(), 0);
    out_ready = 1'b1;
    idle(4);

    // Flush with a full DEPTH=3 pipe and a beat offered in the flush cycle.
    cyc(); drive(1'b1, OP_EQ, 32'd1, 32'd1, 5'd7);
    cyc(); drive(1'b1, OP_NE, 32'd1, 32'd1, 5'd8);
    cyc(); drive(1'b1, OP_LTZ, 32'hF000_0000, 32'd0, 5'd9);
    cyc(); drive(1'b1, OP_EQ, 32'd3, 32'd3, 5'd10);
    flush = 1'b1;
    #1;
    check("fl_out_valid_pre", 32'(out_valid3), 1);
    check("fl_out_tag_pre", 32'(out_tag3), 7);
    cyc();
    flush = 1'b0;
    drive(1'b0, OP_EQ, '0, '0, '0);
    check("fl_out_valid_post", 32'(out_valid3), 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("fl_stays_empty", 32'(out_valid3), 0);
    end
    check("fl_queue3", exp_q3.size(), 0);

    // Counter saturation on CNT_W=4, then clear racing a handoff.
    cyc(); cnt_clr = 1'b1;
    cyc(); cnt_clr = 1'b0;
    check("cnt_cleared", 32'({cmp_cnt1, taken_cnt1}), 0);
    for (int k = 0; k < 20; k++) begin
      cyc();
      drive(1'b1, OP_EQ, W'(k), W'(k), TW'(k));
    end
    cyc();
    drive(1'b0, OP_EQ, '0, '0, '0);
    cyc();
    check("cnt_sat_cmp", 32'(cmp_cnt1), 15);
    check("cnt_sat_taken", 32'(taken_cnt1), 15);
    drive(1'b1, OP_EQ, 32'd4, 32'd4, 5'd3);
    cyc();
    drive(1'b0, OP_EQ, '0, '0, '0);
    cnt_clr = 1'b1;
    #1;
    check("cnt_clr_handoff_present", 32'(out_valid1 && out_ready), 1);
    cyc();
    cnt_clr = 1'b0;
    check("cnt_clr_wins_cmp", 32'(cmp_cnt1), 0);
    check("cnt_clr_wins_taken", 32'(taken_cnt1), 0);
    idle(4);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      cyc();
      case ($urandom_range(0, 4))
        0: a = '0;
        1: a = '1;
        2: a = 32'h8000_0000;
        3: a = 32'h7FFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, b, TW'($urandom_range(0, 31)));
    end
    out_ready = 1'b1;
    idle(6);
    check("rnd_drain1", exp_q1.size(), 0);
    check("rnd_drain3", exp_q3.size(), 0);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(1'b1, OP_GEZ, W'(i), '0, TW'(20 + i));
    end
    #1;
    check("ar_busy_before", 32'(out_valid3), 1);
    #1 clrn = 1'b0;
    #1;
    check("ar_out_valid1", 32'(out_valid1), 0);
    check("ar_out_valid3", 32'(out_valid3), 0);
    check("ar_cnt1", 32'({cmp_cnt1, taken_cnt1}), 0);
    check("ar_cnt3", 32'({cmp_cnt3, taken_cnt3}), 0);
    check("ar_out_data3", 32'({out_taken3, out_tag3}), 0);
    check("ar_in_ready3", 32'(in_ready3), 1);
    drive(1'b0, OP_EQ, '0, '0, '0);
    repeat (2) @(posedge clk);
    #3 clrn = 1'b1;
    cyc();
    check("ar_in_ready_after", 32'(in_ready3), 1);
    drive(1'b1, OP_EQ, 32'd9, 32'd9, 5'd21);
    lat1 = 0;
    lat3 = 0;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      drive(1'b0, OP_EQ, '0, '0, '0);
      if (out_valid1 && lat1 == 0) lat1 = n;
      if (out_valid3 && lat3 == 0) lat3 = n;
      if (!out_valid3 && lat3 == 0) check("ar_zero_until_first", 32'({out_taken3, out_tag3}), 0);
      if (lat3 != 0) break;
    end
    check("ar_latency_d1", lat1, 1);
    check("ar_latency_d3", lat3, 3);
    check("ar_first_tag3", 32'({out_taken3, out_tag3}), 32'({1'b1, 5'd21}));
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
